// File: rtl/riscv_dtm_tap.sv
// IEEE 1149.1 TAP controller and instruction decoder for the RISC-V debug transport module.
// Owns IDCODE, BYPASS and DTMCS; DMIACCESS data is shifted by the downstream DMI front end.
module riscv_dtm_tap #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000001,
  parameter logic [5:0]  AbitsValue  = 6'd7
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       td_i,
  output logic       td_o,
  output logic       tdo_oe_o,
  output logic       test_logic_reset_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_dr_o,
  output logic       dmi_access_o,
  output logic       dtmcs_select_o,
  output logic       dmi_reset_o,
  input  logic [1:0] dmi_error_i,
  output logic       dmi_tdi_o,
  input  logic       dmi_tdo_i
);

  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDrScan   = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIrScan   = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IrDmi     = IrLength'(5'h11);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(5'b00101);

  tap_state_e          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_d;
  logic [IrLength-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]         idcode_q, idcode_d;
  logic [31:0]         dtmcs_q, dtmcs_d;
  logic                bypass_q, bypass_d;
  logic                td_q, td_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic                idcode_sel_s, bypass_sel_s;

  assign dtmcs_select_o = (ir_q == IrDtmcs);
  assign dmi_access_o   = (ir_q == IrDmi);
  assign idcode_sel_s   = (ir_q == IrIdcode);
  assign bypass_sel_s   = ~(idcode_sel_s | dtmcs_select_o | dmi_access_o);
  assign dmi_tdi_o      = td_i;
  assign td_o           = td_q;
  assign tdo_oe_o       = tdo_oe_q;

  // TAP state register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= TestLogicReset;
    end else begin
      state_q <= state_d;
    end
  end

  // TAP next-state logic following the standard TMS graph
  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  // State-decode strobes and the TDO source mux
  always_comb begin
    test_logic_reset_o = 1'b0;
    capture_dr_o       = 1'b0;
    shift_dr_o         = 1'b0;
    update_dr_o        = 1'b0;
    td_d               = 1'b0;
    tdo_oe_d           = 1'b0;
    case (state_q)
      TestLogicReset: test_logic_reset_o = 1'b1;
      CaptureDr:      capture_dr_o       = 1'b1;
      UpdateDr:       update_dr_o        = 1'b1;
      ShiftIr: begin
        td_d     = ir_shift_q[0];
        tdo_oe_d = 1'b1;
      end
      ShiftDr: begin
        shift_dr_o = 1'b1;
        tdo_oe_d   = 1'b1;
        if (idcode_sel_s) begin
          td_d = idcode_q[0];
        end else if (dtmcs_select_o) begin
          td_d = dtmcs_q[0];
        end else if (dmi_access_o) begin
          td_d = dmi_tdo_i;
        end else begin
          td_d = bypass_q;
        end
      end
      default: begin
        td_d     = 1'b0;
        tdo_oe_d = 1'b0;
      end
    endcase
  end

  // Pulses only in Update-DR, so a reset mid-scan clears dtmcs_q before any pulse can occur
  assign dmi_reset_o = update_dr_o & dtmcs_select_o & dtmcs_q[16];

  // Instruction register and its shift stage
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    case (state_q)
      TestLogicReset: ir_d       = IrIdcode;
      CaptureIr:      ir_shift_d = IrCapture;
      ShiftIr:        ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
      UpdateIr:       ir_d       = ir_shift_q;
      default: begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
      end
    endcase
  end

  // Data registers: only the one selected by the IR captures or shifts
  always_comb begin
    idcode_d = idcode_q;
    dtmcs_d  = dtmcs_q;
    bypass_d = bypass_q;
    if (state_q == CaptureDr) begin
      if (idcode_sel_s) begin
        idcode_d = IdcodeValue | 32'h00000001;
      end else if (dtmcs_select_o) begin
        dtmcs_d = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmi_error_i, AbitsValue, 4'd1};
      end else if (bypass_sel_s) begin
        bypass_d = 1'b0;
      end else begin
        bypass_d = bypass_q;
      end
    end else if (state_q == ShiftDr) begin
      if (idcode_sel_s) begin
        idcode_d = {td_i, idcode_q[31:1]};
      end else if (dtmcs_select_o) begin
        dtmcs_d = {td_i, dtmcs_q[31:1]};
      end else if (bypass_sel_s) begin
        bypass_d = td_i;
      end else begin
        bypass_d = bypass_q;
      end
    end else begin
      bypass_d = bypass_q;
    end
  end

  // Rising-edge register bank
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q       <= IrIdcode;
      ir_shift_q <= {IrLength{1'b0}};
      idcode_q   <= 32'h0;
      dtmcs_q    <= 32'h0;
      bypass_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      idcode_q   <= idcode_d;
      dtmcs_q    <= dtmcs_d;
      bypass_q   <= bypass_d;
    end
  end

  // TDO is launched on the falling edge so it is stable at the probe's rising-edge sample
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= td_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

endmodule

// File: tb/tb_riscv_dtm_tap.sv
// Scoreboard bench for riscv_dtm_tap: stimulus queues expected TDO bits,
// a monitor pops and compares them whenever tdo_oe_o is high.
module tb_riscv_dtm_tap;

  logic       tck = 1'b0;
  logic       trst_ni;
  logic       tms_i;
  logic       td_i;
  logic       td_o;
  logic       tdo_oe_o;
  logic       test_logic_reset_o;
  logic       shift_dr_o;
  logic       update_dr_o;
  logic       capture_dr_o;
  logic       dmi_access_o;
  logic       dtmcs_select_o;
  logic       dmi_reset_o;
  logic [1:0] dmi_error_i;
  logic       dmi_tdi_o;
  logic       dmi_tdo_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rst_cnt  = 0;
  int   bit_idx  = 0;
  logic exp_q[$];

  riscv_dtm_tap dut (
    .tck_i              (tck),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .td_i               (td_i),
    .td_o               (td_o),
    .tdo_oe_o           (tdo_oe_o),
    .test_logic_reset_o (test_logic_reset_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o),
    .dmi_access_o       (dmi_access_o),
    .dtmcs_select_o     (dtmcs_select_o),
    .dmi_reset_o        (dmi_reset_o),
    .dmi_error_i        (dmi_error_i),
    .dmi_tdi_o          (dmi_tdi_o),
    .dmi_tdo_i          (dmi_tdo_i)
  );

  always #10 tck = ~tck;

  // Monitor: mid low phase, after td_o has settled from the falling edge
  always begin
    @(negedge tck);
    #5;
    if (dmi_reset_o) rst_cnt++;
    n_checks++;
    if (tdo_oe_o) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tdo_unexpected: tdo_oe_o=1 td_o=%b with no expected bit queued", td_o);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (td_o !== e) begin
          n_fail++;
          $display("FAIL tdo_bit[%0d]: got %b expected %b", bit_idx, td_o, e);
        end
        bit_idx++;
      end
    end else if (td_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tdo_idle: got %b expected 0 while tdo_oe_o=0", td_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic clk(input logic tms, input logic tdi);
    @(negedge tck);
    #1;
    tms_i = tms;
    td_i  = tdi;
    @(posedge tck);
    #2;
  endtask

  task automatic ir_scan(input logic [4:0] v);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) clk(i == 4, v[i]);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  // DR scan from Run-Test/Idle back to Run-Test/Idle, with optional pause or trst abort
  task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] dtdo,
                         input int pause_at, input int abort_at, input bit strobes);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    if (strobes) begin
      chk("capture_dr_o@CapDR", capture_dr_o, 1);
      chk("shift_dr_o@CapDR", shift_dr_o, 0);
      chk("dmi_access_o@CapDR", dmi_access_o, 1);
    end
    clk(1'b0, 1'b0);
    if (strobes) begin
      chk("shift_dr_o@ShDR", shift_dr_o, 1);
      chk("capture_dr_o@ShDR", capture_dr_o, 0);
    end
    for (int i = 0; i < n; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        @(negedge tck);
        #2;
        trst_ni = 1'b0;
        tms_i   = 1'b1;
        #2;
        chk("tlr_after_trst", test_logic_reset_o, 1);
        chk("dmi_access_after_trst", dmi_access_o, 0);
        chk("shift_dr_after_trst", shift_dr_o, 0);
        chk("tdo_oe_after_trst", tdo_oe_o, 0);
        chk("dmi_reset_cnt_abort", rst_cnt, 0);
        return;
      end
      dmi_tdo_i = dtdo[i];
      clk((i == n - 1) || (i == pause_at - 1), din[i]);
      if (pause_at != 0 && i == pause_at - 1) begin
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
      end
    end
    clk(1'b1, 1'b0);
    if (strobes) begin
      chk("update_dr_o@UpdDR", update_dr_o, 1);
      chk("shift_dr_o@UpdDR", shift_dr_o, 0);
    end
    clk(1'b0, 1'b0);
    if (strobes) chk("update_dr_o@RTI", update_dr_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    trst_ni     = 1'b1;
    tms_i       = 1'b1;
    td_i        = 1'b0;
    dmi_error_i = 2'd0;
    dmi_tdo_i   = 1'b0;
    #5 trst_ni  = 1'b0;
    #10;
    chk("rst_tlr", test_logic_reset_o, 1);
    chk("rst_td_o", td_o, 0);
    chk("rst_tdo_oe", tdo_oe_o, 0);
    chk("rst_dmi_access", dmi_access_o, 0);
    chk("rst_dtmcs_sel", dtmcs_select_o, 0);
    chk("rst_strobes", {shift_dr_o, update_dr_o, capture_dr_o, dmi_reset_o}, 0);
    trst_ni = 1'b1;
    for (int i = 0; i < 5; i++) clk(1'b1, 1'b0);
    chk("tms5_tlr", test_logic_reset_o, 1);
    chk("tms5_tdo_oe", tdo_oe_o, 0);

    // IDCODE read after reset
    clk(1'b0, 1'b0);
    chk("rti_tlr_low", test_logic_reset_o, 0);
    push_bits(32, 64'h1);
    dr_scan(32, 64'h0, 64'h0, 0, 0, 1'b0);

    // Five TMS=1 from Pause-DR, then IDCODE scan held across a pause
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) clk(1'b1, 1'b0);
    chk("pause_to_tlr", test_logic_reset_o, 1);
    clk(1'b0, 1'b0);
    push_bits(32, 64'h1);
    dr_scan(32, 64'hFFFF_FFFF, 64'h0, 10, 0, 1'b0);

    // Unknown IR codes act as BYPASS
    push_bits(5, 64'h05);
    ir_scan(5'h1F);
    chk("ir1f_dmi_access", dmi_access_o, 0);
    chk("ir1f_dtmcs_sel", dtmcs_select_o, 0);
    push_bits(8, 64'h64);
    dr_scan(8, 64'hB2, 64'h0, 0, 0, 1'b0);
    push_bits(5, 64'h05);
    ir_scan(5'h00);
    push_bits(4, 64'hE);
    dr_scan(4, 64'hF, 64'h0, 0, 0, 1'b0);

    // DTMCS capture with and without a sticky DMI error
    push_bits(5, 64'h05);
    ir_scan(5'h10);
    chk("ir10_dtmcs_sel", dtmcs_select_o, 1);
    chk("ir10_dmi_access", dmi_access_o, 0);
    push_bits(32, 64'h1071);
    dr_scan(32, 64'h0, 64'h0, 0, 0, 1'b0);
    dmi_error_i = 2'h3;
    push_bits(32, 64'h1C71);
    dr_scan(32, 64'h0, 64'h0, 0, 0, 1'b0);
    dmi_error_i = 2'h0;

    // dmireset write pulses once; writing zero does not
    rst_cnt = 0;
    push_bits(32, 64'h1071);
    dr_scan(32, 64'h0001_0000, 64'h0, 0, 0, 1'b0);
    chk("dmi_reset_pulse_cnt", rst_cnt, 1);
    rst_cnt = 0;
    push_bits(32, 64'h1071);
    dr_scan(32, 64'h0, 64'h0, 0, 0, 1'b0);
    chk("dmi_reset_no_pulse", rst_cnt, 0);

    // DMIACCESS: pass-through data path and strobe order
    push_bits(5, 64'h05);
    ir_scan(5'h11);
    chk("ir11_dmi_access", dmi_access_o, 1);
    chk("ir11_dtmcs_sel", dtmcs_select_o, 0);
    td_i = 1'b1;
    #1 chk("dmi_tdi_hi", dmi_tdi_o, 1);
    td_i = 1'b0;
    #1 chk("dmi_tdi_lo", dmi_tdi_o, 0);
    push_bits(41, 64'h0_15A_3C96_E1);
    dr_scan(41, 64'h1_2345_6789, 64'h0_15A_3C96_E1, 0, 0, 1'b1);

    // trst mid-scan at bit 20
    rst_cnt = 0;
    push_bits(20, 64'h0_9C3A5);
    dr_scan(41, 64'h0, 64'h1_F0F0_9C3A5, 0, 20, 1'b0);
    #20;
    trst_ni = 1'b1;
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    chk("post_trst_tlr", test_logic_reset_o, 1);
    chk("post_trst_dmi_access", dmi_access_o, 0);
    chk("post_trst_dmi_reset_cnt", rst_cnt, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
